gcm_ctr_gen_256: RTL and testbench

Counter-block generator that sits directly upstream of the two-lane (2x128) pipelined AES-256 encryptor in the GCM datapath.
- Per message, it issues one header word {J0, 128'h0} so the core returns E(K,J0) for the tag and H=E(K,0) for GHASH.
- It then issues N data words of two consecutive inc32 counter blocks.
- A cen-qualified delay line matched to the core latency tags each returning keystream word as valid, header or last.

---
 rtl/gcm_ctr_gen_256.sv | 106 ++++++++++
 tb/tb_gcm_ctr_gen_256.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gcm_ctr_gen_256.sv
// Counter-block generator for the two-lane AES-256 core in the GCM datapath.
// Issues {J0,0} then inc32 counter pairs, and tags each keystream word on its return.
//
// state | meaning
// IDLE  | waiting for start; aes_vld low
// HDR   | header word {J0, 0} on aes_din
// DATA  | a data counter pair on aes_din
// DRAIN | issue finished; waiting for the last-tagged word to leave the core
module gcm_ctr_gen_256 #(
   parameter int          AES_LAT  = 28,
   parameter int          NW_W     = 16,
   parameter logic [31:0] CNT_INIT = 32'd2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cen,
   input  logic            start,
   input  logic [95:0]     iv,
   input  logic [NW_W-1:0] nwords,
   output logic [255:0]    aes_din,
   output logic            aes_vld,
   output logic            busy,
   output logic            ks_vld,
   output logic            ks_hdr,
   output logic            ks_last,
   output logic            done
);

   typedef enum logic [1:0] {IDLE, HDR, DATA, DRAIN} stateT;

   stateT             state;
   logic [95:0]       ivReg;
   logic [NW_W-1:0]   remWords;
   logic [31:0]       cnt;
   logic              hdrTag;
   logic              lastTag;
   logic [AES_LAT-1:0] dlyVld;
   logic [AES_LAT-1:0] dlyHdr;
   logic [AES_LAT-1:0] dlyLast;

   assign ks_vld  = dlyVld[AES_LAT-1];
   assign ks_hdr  = dlyHdr[AES_LAT-1];
   assign ks_last = dlyLast[AES_LAT-1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         ivReg    <= '0;
         remWords <= '0;
         cnt      <= '0;
         aes_din  <= '0;
         aes_vld  <= 1'b0;
         hdrTag   <= 1'b0;
         lastTag  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         dlyVld   <= '0;
         dlyHdr   <= '0;
         dlyLast  <= '0;
      end else if (cen) begin
         // Tags follow the word currently on aes_din, so they emerge AES_LAT cycles after issue.
         dlyVld  <= {dlyVld[AES_LAT-2:0], aes_vld};
         dlyHdr  <= {dlyHdr[AES_LAT-2:0], hdrTag};
         dlyLast <= {dlyLast[AES_LAT-2:0], lastTag};
         done    <= dlyVld[AES_LAT-2] & dlyLast[AES_LAT-2];
         case (state)
            IDLE: begin
               if (start) begin
                  ivReg    <= iv;
                  remWords <= nwords;
                  cnt      <= CNT_INIT;
                  aes_din  <= {iv, 32'd1, 128'h0};
                  aes_vld  <= 1'b1;
                  hdrTag   <= 1'b1;
                  lastTag  <= (nwords == '0);
                  busy     <= 1'b1;
                  state    <= HDR;
               end
            end
            HDR, DATA: begin
               hdrTag <= 1'b0;
               if (remWords != '0) begin
                  aes_din  <= {ivReg, cnt, ivReg, cnt + 32'd1};
                  aes_vld  <= 1'b1;
                  lastTag  <= (remWords == NW_W'(1));
                  remWords <= remWords - NW_W'(1);
                  cnt      <= cnt + 32'd2;
                  state    <= DATA;
               end else begin
                  aes_vld <= 1'b0;
                  lastTag <= 1'b0;
                  state   <= DRAIN;
               end
            end
            DRAIN: begin
               if (ks_vld & ks_last) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gcm_ctr_gen_256.sv
// Bench for gcm_ctr_gen_256: a message-level model predicts every output each cycle,
// with literal checks pinning counter values, latency and wrap behaviour.
module tb_gcm_ctr_gen_256;

   localparam int          AES_LAT = 28;
   localparam int          NW_W    = 16;
   localparam logic [31:0] INIT_A  = 32'd2;
   localparam logic [31:0] INIT_B  = 32'hFFFFFFFE;
   localparam logic [95:0] IV1     = 96'hCAFEBABEFACEDBADDECAF888;
   localparam logic [95:0] IV2     = 96'h0123456789ABCDEF00112233;

   logic            clk = 1'b0;
   logic            reset;
   logic            cen;
   logic            start;
   logic [95:0]     iv;
   logic [NW_W-1:0] nwords;

   logic [255:0] dinA, dinB;
   logic vldA, busyA, ksVldA, ksHdrA, ksLastA, doneA;
   logic vldB, busyB, ksVldB, ksHdrB, ksLastB, doneB;

   gcm_ctr_gen_256 #(.AES_LAT(AES_LAT), .NW_W(NW_W), .CNT_INIT(INIT_A)) dutA (
      .clk(clk), .reset(reset), .cen(cen), .start(start), .iv(iv), .nwords(nwords),
      .aes_din(dinA), .aes_vld(vldA), .busy(busyA), .ks_vld(ksVldA),
      .ks_hdr(ksHdrA), .ks_last(ksLastA), .done(doneA));

   gcm_ctr_gen_256 #(.AES_LAT(AES_LAT), .NW_W(NW_W), .CNT_INIT(INIT_B)) dutB (
      .clk(clk), .reset(reset), .cen(cen), .start(start), .iv(iv), .nwords(nwords),
      .aes_din(dinB), .aes_vld(vldB), .busy(busyB), .ks_vld(ksVldB),
      .ks_hdr(ksHdrB), .ks_last(ksLastB), .done(doneB));

   always #5 clk = ~clk;

   int nCmp = 0;
   int nBad = 0;
   bit chkEn = 1'b0;

   task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
      nCmp++;
      if (act !== exp) begin
         nBad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [255:0] wordOf(input int w, input logic [31:0] init, input logic [95:0] v);
      logic [31:0] c;
      if (w < 0) return {v, 32'd1, 128'h0};
      c = init + 32'(2 * w);
      return {v, c, v, c + 32'd1};
   endfunction

   // Message-level model: a queue of words still to issue and a history of issued tags.
   bit           mBusy;
   int           wq[$];
   logic [95:0]  mIv;
   int           mN;
   int           cenCyc = 0;
   logic [255:0] expDinA, expDinB;
   bit           expVld, expDone;
   bit [2:0]     expKs;
   bit [2:0]     tagHist[int];

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mBusy = 1'b0;
         wq.delete();
         tagHist.delete();
         expDinA = '0;
         expDinB = '0;
         expVld  = 1'b0;
         expKs   = '0;
         expDone = 1'b0;
      end else if (cen) begin
         bit       doneNow;
         bit [2:0] tag;
         doneNow = expDone;
         cenCyc++;
         if (!mBusy && start) begin
            mBusy = 1'b1;
            mIv   = iv;
            mN    = int'(nwords);
            wq.push_back(-1);
            for (int i = 0; i < mN; i++) wq.push_back(i);
         end else if (mBusy && doneNow) begin
            mBusy = 1'b0;
         end
         tag = '0;
         if (wq.size() > 0) begin
            int w;
            w       = wq.pop_front();
            expVld  = 1'b1;
            expDinA = wordOf(w, INIT_A, mIv);
            expDinB = wordOf(w, INIT_B, mIv);
            tag     = {1'b1, (w < 0), (w < 0) ? (mN == 0) : (w == mN - 1)};
         end else begin
            expVld = 1'b0;
         end
         tagHist[cenCyc] = tag;
         if (tagHist.exists(cenCyc - AES_LAT)) begin
            expKs = tagHist[cenCyc - AES_LAT];
            tagHist.delete(cenCyc - AES_LAT);
         end else begin
            expKs = '0;
         end
         expDone = expKs[2] & expKs[0];
      end
   end

   always @(negedge clk) begin
      if (chkEn) begin
         check("dinA", dinA, expDinA);
         check("dinB", dinB, expDinB);
         check("ctrlA vld/busy/ksv/ksh/ksl/done", {vldA, busyA, ksVldA, ksHdrA, ksLastA, doneA},
               {expVld, mBusy, expKs, expDone});
         check("ctrlB vld/busy/ksv/ksh/ksl/done", {vldB, busyB, ksVldB, ksHdrB, ksLastB, doneB},
               {expVld, mBusy, expKs, expDone});
      end
   end

   task automatic startMsg(input logic [95:0] v, input int n);
      @(posedge clk); #2;
      start  = 1'b1;
      iv     = v;
      nwords = NW_W'(n);
      @(posedge clk); #2;
      start  = 1'b0;
   endtask

   task automatic waitIdle();
      int k;
      k = 0;
      while (busyA && k < 300) begin
         @(negedge clk);
         k++;
      end
      check("waitIdle timeout", 256'(k < 300), 256'(1));
   endtask

   initial begin
      int lat;
      reset = 1'b1; cen = 1'b1; start = 1'b0; iv = '0; nwords = '0;
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      chkEn = 1'b1;
      @(negedge clk);
      check("rst dinA", dinA, 256'h0);
      check("rst ctrlA", 256'({vldA, busyA, ksVldA, ksHdrA, ksLastA, doneA}), 256'h0);

      // Basic message, with the wrap-hook instance checked alongside.
      startMsg(IV1, 3);
      @(negedge clk);
      check("t1 hdr", dinA, {IV1, 32'h00000001, 128'h0});
      check("t1 busy", 256'(busyA), 256'(1));
      @(negedge clk);
      check("t1 w1", dinA, {IV1, 32'h2, IV1, 32'h3});
      check("wrap w1", dinB, {IV1, 32'hFFFFFFFE, IV1, 32'hFFFFFFFF});
      @(negedge clk);
      check("t1 w2", dinA, {IV1, 32'h4, IV1, 32'h5});
      check("wrap w2", dinB, {IV1, 32'h00000000, IV1, 32'h00000001});
      @(negedge clk);
      check("t1 w3", dinA, {IV1, 32'h6, IV1, 32'h7});
      lat = 3;
      while (!ksVldA && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      check("t1 latency", 256'(lat), 256'(28));
      check("t1 ks_hdr first", 256'({ksHdrA, ksLastA}), 256'(2'b10));
      repeat (3) @(negedge clk);
      check("t1 last/done", 256'({ksVldA, ksLastA, doneA}), 256'(3'b111));
      @(negedge clk);
      check("t1 busy clear", 256'({busyA, doneA}), 256'(2'b00));

      // Header-only message.
      startMsg(IV2, 0);
      @(negedge clk);
      check("t2 hdr", dinA, {IV2, 32'h1, 128'h0});
      lat = 0;
      while (!ksVldA && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      check("t2 latency", 256'(lat), 256'(28));
      check("t2 hdr/last/done", 256'({ksHdrA, ksLastA, doneA}), 256'(3'b111));
      @(negedge clk);
      check("t2 busy clear", 256'(busyA), 256'(0));

      // Clock-enable stalls mid-DATA and mid-DRAIN.
      startMsg({$urandom, $urandom, $urandom}, 8);
      repeat (3) @(posedge clk);
      #2 cen = 1'b0;
      repeat (5) @(posedge clk);
      #2 cen = 1'b1;
      repeat (10) @(posedge clk);
      #2 cen = 1'b0;
      repeat (5) @(posedge clk);
      #2 cen = 1'b1;
      waitIdle();

      // Start held through a whole message, including its done cycle.
      startMsg(IV1, 4);
      start = 1'b1;
      iv    = IV2;
      lat = 0;
      while (!doneA && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check("t5 done seen", 256'(doneA), 256'(1));
      @(posedge clk); #2;
      @(posedge clk); #2;
      start = 1'b0;
      @(negedge clk);
      check("t5 restart hdr", dinA, {IV2, 32'h1, 128'h0});
      waitIdle();

      // Reset mid-message, then a clean restart.
      startMsg(IV2, 20);
      repeat (10) @(posedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      check("t6 rst din", dinA, 256'h0);
      check("t6 rst ctrl", 256'({vldA, busyA, ksVldA, ksHdrA, ksLastA, doneA}), 256'h0);
      @(posedge clk);
      #2 reset = 1'b0;
      repeat (40) @(posedge clk);
      startMsg(IV1, 1);
      @(negedge clk);
      check("t6 hdr", dinA, {IV1, 32'h1, 128'h0});
      @(negedge clk);
      check("t6 w1", dinA, {IV1, 32'h2, IV1, 32'h3});
      waitIdle();

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #2;
         cen    = ($urandom % 5) != 0;
         start  = ($urandom % 6) == 0;
         iv     = {$urandom, $urandom, $urandom};
         nwords = NW_W'($urandom_range(0, 5));
         reset  = ($urandom % 700) == 0;
      end
      @(posedge clk); #2;
      reset = 1'b0; cen = 1'b1; start = 1'b0;
      repeat (80) @(posedge clk);
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

endmodule
